// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one combinational ALU among N_REQ requesters,
// with registered operands and a tagged, registered response handshake.

module alu #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       Sel,
   output logic [WIDTH-1:0] Out,
   output logic             Zero
);
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      Out = '0;
      case (Sel)
         3'b000: Out = A + B;
         3'b001: Out = A - B;
         3'b010: Out = A & B;
         3'b011: Out = A | B;
         3'b100: Out = A ^ B;
         3'b101: Out = A << 1;
         3'b110: Out = A >> 1;
         3'b111: Out = {{(WIDTH-1){1'b0}}, (A < B)};
         default: Out = '0;
      endcase
      Zero = (Out == '0);
   end
endmodule

module alu_arbiter #(
   parameter int WIDTH = 8,
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_A,
   input  logic [N_REQ*WIDTH-1:0] req_B,
   input  logic [N_REQ*3-1:0]     req_Sel,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_Out,
   output logic                   rsp_Zero,
   output logic                   busy
);
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t            state, next;
   logic [ID_W-1:0]   last_grant, cur_id, grant_idx;
   logic [WIDTH-1:0]  op_a, op_b, alu_out;
   logic [2:0]        op_sel;
   logic              alu_zero, found, accept;
   logic [ID_W:0]     sh;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]  rot;
   int                idx;

   alu #(.WIDTH(WIDTH)) u_alu (
      .A(op_a), .B(op_b), .Sel(op_sel), .Out(alu_out), .Zero(alu_zero)
   );

   // Rotate valids so bit 0 is the requester after last_grant, then pick the lowest set bit.
   always_comb begin
      found     = 1'b0;
      idx       = 0;
      req_ready = '0;
      sh        = {1'b0, last_grant} + (ID_W+1)'(1);
      dbl       = {req_valid, req_valid};
      rot       = N_REQ'(dbl >> sh);
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            idx   = k + int'(sh);
         end
      end
      if (idx >= N_REQ) idx = idx - N_REQ;
      grant_idx = ID_W'(idx);
      if (state == IDLE && found) req_ready = N_REQ'(1) << grant_idx;
   end

   assign accept = |(req_ready & req_valid);
   assign busy   = (state != IDLE);

   always_comb begin
      next = state;
      case (state)
         IDLE:    if (accept) next = EXEC;
         EXEC:    next = HOLD;
         HOLD:    if (rsp_ready) next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= ID_W'(N_REQ-1);
         cur_id     <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_sel     <= '0;
         rsp_valid  <= 1'b0;
         rsp_Out    <= '0;
         rsp_Zero   <= 1'b0;
         rsp_id     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= next;
         case (state)
            IDLE: if (accept) begin
               op_a       <= req_A[grant_idx*WIDTH +: WIDTH];
               op_b       <= req_B[grant_idx*WIDTH +: WIDTH];
               op_sel     <= req_Sel[grant_idx*3 +: 3];
               last_grant <= grant_idx;
               cur_id     <= grant_idx;
            end
            EXEC: begin
               rsp_Out   <= alu_out;
               rsp_Zero  <= alu_zero;
               rsp_id    <= cur_id;
               rsp_valid <= 1'b1;
            end
            HOLD: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with hand-computed expectations.

module tb_alu_arbiter;
   localparam int WIDTH = 8;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [N_REQ-1:0]       req_valid = '0;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_A = '0;
   logic [N_REQ*WIDTH-1:0] req_B = '0;
   logic [N_REQ*3-1:0]     req_Sel = '0;
   logic                   rsp_valid;
   logic                   rsp_ready = 1'b1;
   logic [ID_W-1:0]        rsp_id;
   logic [WIDTH-1:0]       rsp_Out;
   logic                   rsp_Zero;
   logic                   busy;

   int n_vec = 0;
   int n_err = 0;

   alu_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_A(req_A), .req_B(req_B), .req_Sel(req_Sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_Out(rsp_Out), .rsp_Zero(rsp_Zero), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      req_A[i*WIDTH +: WIDTH] = a;
      req_B[i*WIDTH +: WIDTH] = b;
      req_Sel[i*3 +: 3]       = s;
   endtask

   // Single requester i issues one op; rsp_ready stays high so HOLD lasts one cycle.
   task automatic do_op(input string tag, input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] s, input logic [7:0] exp_out, input logic exp_zero);
      set_req(i, a, b, s);
      req_valid = N_REQ'(1) << i;
      #1;
      check({tag, "_ready"}, req_ready, N_REQ'(1) << i);
      tick();
      req_valid = '0;
      check({tag, "_exec_valid"}, rsp_valid, 0);
      tick();
      check({tag, "_valid"}, rsp_valid, 1);
      check({tag, "_out"}, rsp_Out, exp_out);
      check({tag, "_zero"}, rsp_Zero, exp_zero);
      check({tag, "_id"}, rsp_id, i);
      tick();
      check({tag, "_done"}, rsp_valid, 0);
   endtask

   initial begin
      do_reset();
      check("rst_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out", rsp_Out, 0);
      check("rst_zero", rsp_Zero, 0);
      check("rst_id", rsp_id, 0);
      check("rst_ready", req_ready, 0);

      do_op("single", 2, 8'h05, 8'h03, 3'b000, 8'h08, 1'b0);
      do_op("subzero", 0, 8'h10, 8'h10, 3'b001, 8'h00, 1'b1);
      do_op("subwrap", 0, 8'h00, 8'h01, 3'b001, 8'hFF, 1'b0);
      do_op("ltu_f", 3, 8'h80, 8'h01, 3'b111, 8'h00, 1'b1);
      do_op("ltu_t", 3, 8'h01, 8'h80, 3'b111, 8'h01, 1'b0);
      do_op("shl", 1, 8'h81, 8'h00, 3'b101, 8'h02, 1'b0);
      do_op("shr", 1, 8'h81, 8'h00, 3'b110, 8'h40, 1'b0);
      do_op("and", 2, 8'hF0, 8'h3C, 3'b010, 8'h30, 1'b0);
      do_op("xor", 2, 8'hAA, 8'hAA, 3'b100, 8'h00, 1'b1);

      // Round robin: requester i adds 0x10 to i+1.
      for (int i = 0; i < N_REQ; i++) set_req(i, 8'(i + 1), 8'h10, 3'b000);
      do_reset();
      req_valid = '1;
      for (int n = 0; n < 6; n++) begin
         int g;
         g = n % N_REQ;
         #1;
         check($sformatf("rr%0d_ready", n), req_ready, N_REQ'(1) << g);
         tick();
         tick();
         check($sformatf("rr%0d_id", n), rsp_id, g);
         check($sformatf("rr%0d_out", n), rsp_Out, 8'h11 + 8'(g));
         tick();
      end

      // Backpressure: requester 0 granted first after reset, consumer stalls.
      do_reset();
      rsp_ready = 1'b0;
      req_valid = '1;
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp%0d_valid", c), rsp_valid, 1);
         check($sformatf("bp%0d_out", c), rsp_Out, 8'h11);
         check($sformatf("bp%0d_id", c), rsp_id, 0);
         check($sformatf("bp%0d_ready", c), req_ready, 0);
         check($sformatf("bp%0d_busy", c), busy, 1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_release_valid", rsp_valid, 0);
      check("bp_next_grant", req_ready, 4'b0010);
      req_valid = '0;
      tick();
      check("bp_once", rsp_valid, 0);

      // Reset mid-op: complete grants 0 and 1, accept 2, then reset in EXEC.
      do_reset();
      req_valid = '1;
      repeat (6) tick();
      check("mid_pre_out", rsp_Out, 8'h12);
      check("mid_pre_id", rsp_id, 1);
      tick();
      check("mid_exec_busy", busy, 1);
      req_valid = '0;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", rsp_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out", rsp_Out, 0);
      check("mid_rst_id", rsp_id, 0);
      check("mid_rst_zero", rsp_Zero, 0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("mid_novalid%0d", c), rsp_valid, 0);
         tick();
      end
      req_valid = '1;
      #1;
      check("mid_first_grant", req_ready, 4'b0001);
      tick();
      tick();
      check("mid_first_id", rsp_id, 0);
      check("mid_first_out", rsp_Out, 8'h11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
